sdram_pro_arbit: RTL

SDRAM_PRO_ARBIT -- requirements
Module: sdram_pro_arbit

---
 rtl/sdram_pro_arbit_pkg.sv | 11 +
 rtl/sdram_pro_arbit.sv | 93 +++++++++
 2 files changed

// File: rtl/sdram_pro_arbit_pkg.sv
// sdram_pro_arbit_pkg: SDRAM command encodings {cs_n, ras_n, cas_n, we_n} shared by the controller blocks
package sdram_pro_arbit_pkg;
  localparam logic [3:0] CMD_NOP          = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
  localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;
  localparam logic [3:0] CMD_ACTIVE       = 4'b0011;
  localparam logic [3:0] CMD_WRITE        = 4'b0100;
  localparam logic [3:0] CMD_READ         = 4'b0101;
  localparam logic [3:0] CMD_BURST_STOP   = 4'b0110;
endpackage

// File: rtl/sdram_pro_arbit.sv
// sdram_pro_arbit: arbitrates init/refresh/write/read submodules onto one SDRAM command bus
module sdram_pro_arbit
  import sdram_pro_arbit_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 1023
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [1:0]        init_bank,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic [1:0]        aref_bank,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [1:0]        wr_bank,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_bank,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [1:0]        sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic              arb_err
);
  localparam logic [2:0] INIT  = 3'd0;
  localparam logic [2:0] ARBIT = 3'd1;
  localparam logic [2:0] AREF  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] READ  = 3'd4;
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [2:0]    state, nxt;
  logic [CW-1:0] cnt;
  logic          last_wr;
  logic          granted, done, expired;
  logic [3:0]    cmd;
  assign aref_en = state == AREF;
  assign wr_en   = state == WRITE;
  assign rd_en   = state == READ;
  assign granted = aref_en | wr_en | rd_en;
  // only the end pulse of the currently granted requester counts
  assign done    = aref_en ? aref_end : wr_en ? wr_end : rd_en ? rd_end : 1'b0;
  assign expired = granted & ~done & (cnt == CW'(TIMEOUT - 1));
  always_comb begin
    nxt = state;
    case (state)
      INIT:    nxt = init_end ? ARBIT : INIT;
      ARBIT:   nxt = aref_req ? AREF :
                     (wr_req & rd_req) ? (last_wr ? READ : WRITE) :
                     wr_req ? WRITE : rd_req ? READ : ARBIT;
      AREF,
      WRITE,
      READ:    nxt = (done | expired) ? ARBIT : state;
      default: nxt = INIT;
    endcase
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= INIT;
      cnt     <= '0;
      last_wr <= 1'b0;
      arb_err <= 1'b0;
    end else begin
      state   <= nxt;
      cnt     <= (granted && nxt == state) ? cnt + CW'(1) : '0;
      arb_err <= arb_err | expired;
      if (state == ARBIT && nxt == WRITE) last_wr <= 1'b1;
      if (state == ARBIT && nxt == READ) last_wr <= 1'b0;
    end
  end
  always_comb begin
    cmd        = state == INIT ? init_cmd : aref_en ? aref_cmd : wr_en ? wr_cmd : rd_en ? rd_cmd : CMD_NOP;
    sdram_addr = state == INIT ? init_addr : aref_en ? aref_addr : wr_en ? wr_addr : rd_en ? rd_addr : '1;
    sdram_ba   = state == INIT ? init_bank : aref_en ? aref_bank : wr_en ? wr_bank : rd_en ? rd_bank : 2'b11;
  end
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
  assign sdram_cke = 1'b1;
endmodule
